// File: rtl/db_led_pwm_pkg.sv
// Shared types and field positions for the LED configuration register.
// led_cfg_t mirrors the 32-bit register value from the bus slave:
//   [7:0] mask, [15:8] duty, [23:16] prescaler, [27:24] blink rate,
//   [30:28] reserved, [31] enable.
package db_led_pwm_pkg;

  localparam int unsigned CFG_W     = 32;
  localparam int unsigned MASK_LSB  = 0;
  localparam int unsigned DUTY_LSB  = 8;
  localparam int unsigned PRESC_LSB = 16;
  localparam int unsigned RATE_LSB  = 24;
  localparam int unsigned RSVD_LSB  = 28;
  localparam int unsigned EN_BIT    = 31;
  localparam int unsigned FIELD_W   = 8;
  localparam int unsigned RATE_W    = 4;

  localparam logic [FIELD_W-1:0] PWM_MAX = 8'hFF;

  typedef struct packed {
    logic              enable;
    logic [2:0]        rsvd;
    logic [RATE_W-1:0] rate;
    logic [7:0]        presc;
    logic [7:0]        duty;
    logic [7:0]        mask;
  } led_cfg_t;

endpackage

// File: rtl/db_led_pwm_if.sv
// LED PWM port bundle: configuration word in, LED drive and period pulse out.
//   cfg_i        : 32-bit register value from the bus slave
//   led_o        : NUM_LEDS LED drive (registered)
//   period_end_o : one-cycle pulse on PWM wrap (registered)
// master = register/bus side, slave = PWM block.
interface db_led_pwm_if #(
  parameter int unsigned NUM_LEDS = 8
);
  logic [31:0]         cfg_i;
  logic [NUM_LEDS-1:0] led_o;
  logic                period_end_o;

  modport master (output cfg_i, input led_o, input period_end_o);
  modport slave  (input cfg_i, output led_o, output period_end_o);
endinterface

// File: rtl/db_led_pwm_tick.sv
// Prescaler tick generator: tick fires when the count matches presc, then the
// count restarts, giving one tick every presc+1 clocks while run is high.
//   clk, rst (async, active-low), run, presc[7:0] in; tick out.
// tick is decoded from the count so the PWM counter advances on the same edge
// the prescaler restarts.
module db_led_pwm_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] cnt;

  assign tick = run & (cnt == presc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/db_led_pwm.sv
// LED brightness controller fed by the LED configuration register.
// An 8-bit PWM with prescaler drives NUM_LEDS outputs; configuration is
// shadowed and reloaded only on PWM wrap so the outputs never glitch.
// Ports: clk, rst (async, active-low), bus (db_led_pwm_if.slave: cfg_i in,
//        led_o / period_end_o out, both registered).
// Optional blinking is built when DB_LED_PWM_BLINK_EN is defined.
module db_led_pwm
  import db_led_pwm_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned BLINK_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  db_led_pwm_if.slave    bus
);

  led_cfg_t            cfg;
  led_cfg_t            shd;
  logic [7:0]          pwm_cnt;
  logic                tick;
  logic                wrap;
  logic                pwm_on;
  logic                phase_eff;
  logic [NUM_LEDS-1:0] led_q;
  logic                period_end_q;

  assign cfg  = led_cfg_t'(bus.cfg_i);
  assign wrap = tick & (pwm_cnt == PWM_MAX);

  // Shadow: transparent while disabled, reload on wrap, disable is immediate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd <= '0;
    end else if (!cfg.enable || !shd.enable || wrap) begin
      shd <= cfg;
    end
  end

  db_led_pwm_tick u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (shd.enable),
    .presc (shd.presc),
    .tick  (tick)
  );

  // PWM counter, modulo 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
    end else if (!shd.enable) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

`ifdef DB_LED_PWM_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_lim;
  logic               phase;

  assign blink_lim = (BLINK_W'(1) << shd.rate) - BLINK_W'(1);
  // Rate 0 forces the phase on at once, even straight after a reload.
  assign phase_eff = phase | (shd.rate == 4'd0);

  // Blink counter counts period ends; phase toggles every 2^R periods.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!shd.enable || (shd.rate == 4'd0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == blink_lim) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end
`else
  assign phase_eff = 1'b1;
  // Blink width only matters when blinking is built in.
  logic [BLINK_W-1:0] unused_blink_w;
  assign unused_blink_w = '0;
`endif

  assign pwm_on = shd.duty > pwm_cnt;

  // Output stage, one register after the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q        <= '0;
      period_end_q <= 1'b0;
    end else begin
      led_q        <= (shd.enable & pwm_on & phase_eff) ? shd.mask[NUM_LEDS-1:0] : '0;
      period_end_q <= wrap;
    end
  end

  assign bus.led_o        = led_q;
  assign bus.period_end_o = period_end_q;

  // Reserved/upper fields are carried in the shadow but not decoded here.
  logic unused_shd;
  assign unused_shd = ^shd;

endmodule

// File: doc/db_led_pwm.md
Name: db_led_pwm

Overview:
Downstream consumer of the LED configuration register on the data bus. It takes the 32-bit register value (`reg_data_o` of the register slave at `CFG_BADR_LED`) and drives NUM_LEDS LED outputs. The LEDs are brightness-controlled by an 8-bit PWM with a programmable prescaler and optional blinking. Config changes are shadowed and applied only at PWM period boundaries, so outputs never glitch.

Parameters:
NUM_LEDS, 8, number of LED outputs (1..8); mask field bits [NUM_LEDS-1:0] used, rest ignored
BLINK_W, 16, width of blink period counter; must be >= 15

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
cfg_i  input  32  register value from bus slave; [7:0] led mask, [15:8] duty, [23:16] prescaler P, [27:24] blink rate R, [30:28] reserved, [31] enable
led_o  output  NUM_LEDS  LED drive, registered
period_end_o  output  1  one-cycle pulse on PWM counter wrap 255->0, registered

Behaviour:
- Reset (rst low, async): shadow cfg = 0, prescale cnt = 0, pwm cnt = 0, blink cnt = 0, blink phase = 1, led_o = 0, period_end_o = 0.
- Shadow load: when shadow.enable = 0, shadow <= cfg_i every cycle. When enabled, shadow <= cfg_i only on the cycle the PWM counter wraps. Exception: cfg_i[31] = 0 clears shadow.enable immediately (same edge).
- While shadow.enable = 0: all counters held at 0, blink phase = 1, led_o <= 0, period_end_o <= 0.
- Prescaler: tick asserts when presc_cnt == shadow.P, and presc_cnt then returns to 0; otherwise presc_cnt increments. Tick period = P+1 clocks; P = 0 gives a tick every cycle.
- PWM counter: 8-bit, increments on tick, wraps 255->0 (modulo 256). The wrap cycle asserts period_end_o on the next edge and reloads the shadow.
- pwm_on = (duty > pwm_cnt), unsigned 8-bit compare. duty 0 is never on; duty 255 is on 255/256.
- led_o <= (enable & pwm_on & blink_phase) ? mask[NUM_LEDS-1:0] : 0. One register stage after the counters.
- Latency from disabled: cfg_i with enable = 1 at cycle N is loaded into the shadow at edge N. led_o reflects it at edge N+1 (pwm_cnt = 0).
- New cfg_i while enabled: takes effect at the first pwm_cnt value 0 following the next wrap. Intermediate cfg_i values that change and revert within a period are never seen.
- Simultaneous events: an enable-clear on the wrap cycle takes priority (disable). No other events conflict.

Optional Feature:
Macro: DB_LED_PWM_BLINK_EN.
- Defined:
  - R = 0 means no blink (phase = 1).
  - R > 0: blink cnt counts period ends. When it reaches 2^R - 1 on a period end, it clears and the phase toggles, so the LEDs are on for 2^R periods and off for 2^R periods.
  - Blink cnt and phase reset to 0/1 on disable.
- Undefined: the R field is ignored, the phase is constant 1, and no blink counter is synthesized.

Decomposition:
- Shared package: packed struct led_cfg_t with the field layout above, plus the bit-position constants for the fields. It sits alongside the LED base/mask constants in config_pkg.
- Sub-module: db_led_pwm_tick, the prescaler tick generator with inputs clk, rst, run, presc[7:0] and output tick.

Test Plan:
- mask 0x0F, duty 128, P 0, R 0, enable → led_o = 0x0F for 128 cycles then 0x00 for 128 cycles; period_end_o pulses every 256 cycles.
- duty 0, then duty 255 (mask 0xFF, P 0) → led_o constantly 0; then 0xFF for 255 of every 256 cycles.
- P 3, duty 64 → period_end_o every 1024 cycles; led_o high for 256 cycles per period.
- Duty changed 128→32 at pwm_cnt 10 → the current period keeps its 128-cycle high time; the next period is high for 32 cycles. Disable mid-period → led_o = 0 one edge later, counters at 0.
- BLINK_EN defined, R 1, duty 255 → on for 2 periods, off for 2 periods, repeating. Undefined, same config → on every period.
- Assert rst low asynchronously mid-period → led_o and period_end_o are 0 immediately. After release with enable held, output restarts from pwm_cnt 0 with the reloaded shadow.
